// File: rtl/insn_sequencer_pkg.sv
// Package rv_ctrl_pkg: shared types and constants for the multi-cycle RV32I
// control path.
//   seq_state_e  - sequencer FSM states
//   insn_class_e - coarse instruction class that picks the stages to visit
//   OPC_*        - RV32I major opcodes (instruction bits [6:0])
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALT
  } seq_state_e;

  typedef enum logic [2:0] {
    C_ALU,     // OP, OP-IMM, LUI, AUIPC
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,    // JAL, JALR
    C_FENCE,   // MISC-MEM
    C_SYS,     // ECALL/EBREAK and the rest of SYSTEM
    C_ILL
  } insn_class_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/insn_sequencer_if.sv
// Interface bundling every signal between the sequencer and the datapath /
// memories it controls.
//   master - the sequencer: takes decode/execute/memory status, drives all
//            enables, requests, sticky flags and statistics counters
//   slave  - the datapath side, the mirror image of master
interface insn_sequencer_if #(
  parameter int CNTW = 32
);

  // Status into the sequencer
  logic [6:0]      opcode;      // from decode, valid in DECODE and later
  logic [4:0]      rd;          // destination register from decode
  logic            br_taken;    // branch resolution, valid in EXECUTE
  logic            imem_ready;  // instruction memory data available
  logic            dmem_ready;  // data memory access completed

  // Controls out of the sequencer
  logic            imem_req;
  logic            insn_we;
  logic            dec_en;
  logic            exe_en;
  logic            dmem_req;
  logic            dmem_we;
  logic            rf_we;
  logic            pc_we;
  logic            pc_sel;      // 0: PC+4, 1: branch/jump target
  logic            halted;
  logic            illegal;
  logic            bus_err;
  logic [CNTW-1:0] cycle_cnt;
  logic [CNTW-1:0] retired;

  modport master (
    input  opcode, rd, br_taken, imem_ready, dmem_ready,
    output imem_req, insn_we, dec_en, exe_en, dmem_req, dmem_we,
           rf_we, pc_we, pc_sel, halted, illegal, bus_err,
           cycle_cnt, retired
  );

  modport slave (
    output opcode, rd, br_taken, imem_ready, dmem_ready,
    input  imem_req, insn_we, dec_en, exe_en, dmem_req, dmem_we,
           rf_we, pc_we, pc_sel, halted, illegal, bus_err,
           cycle_cnt, retired
  );

endinterface

// File: rtl/insn_sequencer_classifier.sv
// opcode_classifier: purely combinational map from the 7-bit major opcode to
// the instruction class that steers the sequencer.
//   opcode - instruction bits [6:0] from decode
//   cls    - instruction class; C_ILL for any unlisted opcode
module opcode_classifier
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  output insn_class_e cls
);

  always_comb begin
    unique case (opcode)
      OPC_LOAD:     cls = C_LOAD;
      OPC_STORE:    cls = C_STORE;
      OPC_BRANCH:   cls = C_BRANCH;
      OPC_JAL,
      OPC_JALR:     cls = C_JUMP;
      OPC_OP,
      OPC_OP_IMM,
      OPC_LUI,
      OPC_AUIPC:    cls = C_ALU;
      OPC_MISC_MEM: cls = C_FENCE;
      OPC_SYSTEM:   cls = C_SYS;
      // NOTE: every path through combinational logic must assign cls, or a
      // latch is inferred; the default arm covers all remaining encodings.
      default:      cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/insn_sequencer.sv
// insn_sequencer: multi-cycle control FSM for the non-pipelined RV32I core.
// Walks FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK, skipping the
// stages an instruction class does not need, and owns every stage enable.
//   clk  - core clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - master side of insn_sequencer_if (status in, enables/flags/
//          counters out)
// All outputs are registered except the handshake-qualified pulses:
// insn_we (imem_ready in FETCH), the store retire pc_we (dmem_ready in
// MEMORY) and the taken-branch pc_sel (br_taken, resolved in EXECUTE).
module insn_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int CNTW     = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            rst,
  insn_sequencer_if.master bus
);

  localparam int              WAITW      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam bit              TIMEOUT_EN = (MAX_WAIT != 0);
  localparam logic [WAITW-1:0] WAIT_LAST = WAITW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  seq_state_e       state;
  insn_class_e      cls_q;
  insn_class_e      dec_cls;
  logic [WAITW-1:0] wait_cnt;

  logic             imem_req_q, dec_en_q, exe_en_q, dmem_req_q, dmem_we_q;
  logic             rf_we_q, pc_we_q, pc_sel_q;
  logic             halted_q, illegal_q, bus_err_q;
  logic [CNTW-1:0]  cycle_cnt_q, retired_q;

  logic             timeout;
  logic             store_done;
  logic             retire;

  opcode_classifier u_classifier (
    .opcode (bus.opcode),
    .cls    (dec_cls)
  );

  // The final wait cycle is still allowed to complete; the timeout only
  // fires when ready is also absent on that cycle.
  assign timeout    = TIMEOUT_EN && (wait_cnt == WAIT_LAST);

  // A store retires in the same cycle its data access completes.
  assign store_done = (state == S_MEMORY) && (cls_q == C_STORE) && bus.dmem_ready;
  assign retire     = pc_we_q || store_done;

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous and wins in any state.
    if (!rst) begin
      state       <= S_IDLE;
      cls_q       <= C_ALU;
      wait_cnt    <= '0;
      imem_req_q  <= 1'b0;
      dec_en_q    <= 1'b0;
      exe_en_q    <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      pc_we_q     <= 1'b0;
      pc_sel_q    <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      cycle_cnt_q <= '0;
      retired_q   <= '0;
    end else begin
      // Single-cycle enables fall unless the transition below re-asserts them.
      dec_en_q <= 1'b0;
      exe_en_q <= 1'b0;
      rf_we_q  <= 1'b0;
      pc_we_q  <= 1'b0;
      pc_sel_q <= 1'b0;

      if (state != S_HALT) cycle_cnt_q <= sat_inc(cycle_cnt_q);
      if (retire)          retired_q   <= sat_inc(retired_q);

      unique case (state)
        S_IDLE: begin
          state      <= S_FETCH;
          imem_req_q <= 1'b1;
          wait_cnt   <= '0;
        end

        S_FETCH: begin
          if (bus.imem_ready) begin
            state      <= S_DECODE;
            imem_req_q <= 1'b0;
            dec_en_q   <= 1'b1;
          end else if (timeout) begin
            state      <= S_HALT;
            imem_req_q <= 1'b0;
            halted_q   <= 1'b1;
            bus_err_q  <= 1'b1;
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_cnt + WAITW'(1);
          end
        end

        S_DECODE: begin
          cls_q <= dec_cls;
          if (dec_cls == C_SYS || dec_cls == C_ILL) begin
            state     <= S_HALT;
            halted_q  <= 1'b1;
            illegal_q <= (dec_cls == C_ILL);
          end else begin
            state    <= S_EXECUTE;
            exe_en_q <= 1'b1;
            // Branches and fences retire in EXECUTE.
            pc_we_q  <= (dec_cls == C_BRANCH) || (dec_cls == C_FENCE);
          end
        end

        S_EXECUTE: begin
          if (cls_q == C_LOAD || cls_q == C_STORE) begin
            state      <= S_MEMORY;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= (cls_q == C_STORE);
            wait_cnt   <= '0;
          end else if (cls_q == C_BRANCH || cls_q == C_FENCE) begin
            state      <= S_FETCH;
            imem_req_q <= 1'b1;
            wait_cnt   <= '0;
          end else begin
            state    <= S_WRITEBACK;
            rf_we_q  <= (bus.rd != 5'd0);
            pc_we_q  <= 1'b1;
            pc_sel_q <= (cls_q == C_JUMP);
          end
        end

        S_MEMORY: begin
          if (bus.dmem_ready) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (cls_q == C_LOAD) begin
              state   <= S_WRITEBACK;
              rf_we_q <= (bus.rd != 5'd0);
              pc_we_q <= 1'b1;
            end else begin
              state      <= S_FETCH;
              imem_req_q <= 1'b1;
              wait_cnt   <= '0;
            end
          end else if (timeout) begin
            state      <= S_HALT;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halted_q   <= 1'b1;
            bus_err_q  <= 1'b1;
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_cnt + WAITW'(1);
          end
        end

        S_WRITEBACK: begin
          state      <= S_FETCH;
          imem_req_q <= 1'b1;
          wait_cnt   <= '0;
        end

        S_HALT: state <= S_HALT;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.insn_we   = (state == S_FETCH) && bus.imem_ready;
  assign bus.dec_en    = dec_en_q;
  assign bus.exe_en    = exe_en_q;
  assign bus.dmem_req  = dmem_req_q;
  assign bus.dmem_we   = dmem_we_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.pc_we     = retire;
  assign bus.pc_sel    = pc_sel_q ||
                         ((state == S_EXECUTE) && (cls_q == C_BRANCH) && bus.br_taken);
  assign bus.halted    = halted_q;
  assign bus.illegal   = illegal_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_insn_sequencer.sv
// Self-checking bench for insn_sequencer (MAX_WAIT = 4).
// The stimulus thread issues directed instructions and pushes one expected
// retire record per instruction; a negedge monitor measures what the DUT
// does per instruction and compares it against the popped record whenever
// a retire pulse appears. Halt, reset and timeout outcomes are checked
// directly by the stimulus thread.
module tb_insn_sequencer;

  typedef struct {
    string name;
    bit    pc_sel;
    bit    rf_we;
    int    latency;
    int    dmem_cycles;
    bit    dmem_we;
    int    retired_before;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  insn_sequencer_if #(.CNTW(32)) bus ();

  insn_sequencer #(.CNTW(32), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " controls"},
          {bus.imem_req, bus.insn_we, bus.dec_en, bus.exe_en, bus.dmem_req,
           bus.dmem_we, bus.rf_we, bus.pc_we, bus.pc_sel}, 0);
    check({tag, " flags"}, {bus.halted, bus.illegal, bus.bus_err}, 0);
    check({tag, " cycle_cnt"}, bus.cycle_cnt, 0);
    check({tag, " retired"}, bus.retired, 0);
  endtask

  task automatic wait_fetch_or_halt(input string tag);
    int n = 0;
    while (!(bus.imem_req || bus.halted) && n < 32) begin
      step();
      n++;
    end
    if (n >= 32) check({tag, " next-fetch timeout"}, 1, 0);
  endtask

  task automatic do_insn(input string name, input logic [6:0] opc, input logic [4:0] rd,
                         input logic br, input int iwait, input bit use_mem, input int dwait,
                         input bit x_pc_sel, input bit x_rf_we, input int x_lat,
                         input int x_dmem, input bit x_dmem_we, input int x_ret);
    exp_t e;
    int   n;
    e.name = name; e.pc_sel = x_pc_sel; e.rf_we = x_rf_we; e.latency = x_lat;
    e.dmem_cycles = x_dmem; e.dmem_we = x_dmem_we; e.retired_before = x_ret;
    exp_q.push_back(e);
    bus.opcode = opc; bus.rd = rd; bus.br_taken = br;
    wait_fetch_or_halt(name);
    check({name, " imem_req"}, bus.imem_req, 1);
    repeat (iwait) step();
    bus.imem_ready = 1'b1;
    #1;
    check({name, " insn_we"}, bus.insn_we, 1);
    step();
    bus.imem_ready = 1'b0;
    check({name, " dec_en"}, bus.dec_en, 1);
    if (use_mem) begin
      n = 0;
      while (!bus.dmem_req && n < 8) begin
        step();
        n++;
      end
      if (n >= 8) check({name, " dmem_req timeout"}, 1, 0);
      repeat (dwait) step();
      bus.dmem_ready = 1'b1;
      step();
      bus.dmem_ready = 1'b0;
    end
    wait_fetch_or_halt(name);
  endtask

  // Monitor: per-instruction observation, compared at the retire pulse.
  int   cyc = 0, start_cyc = 0, dmem_cycles = 0;
  bit   prev_req = 0, dmem_we_seen = 0, rf_we_seen = 0;
  exp_t me;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_req = 0;
    end else begin
      if (bus.imem_req && !prev_req) begin
        start_cyc = cyc; dmem_cycles = 0; dmem_we_seen = 0; rf_we_seen = 0;
      end
      prev_req = bus.imem_req;
      if (bus.dmem_req) begin
        dmem_cycles++;
        if (bus.dmem_we) dmem_we_seen = 1;
      end
      if (bus.rf_we) rf_we_seen = 1;
      if (bus.pc_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected retire", 1, 0);
        end else begin
          me = exp_q.pop_front();
          check({me.name, " pc_sel"}, bus.pc_sel, me.pc_sel);
          check({me.name, " rf_we"}, rf_we_seen, me.rf_we);
          check({me.name, " latency"}, cyc - start_cyc + 1, me.latency);
          check({me.name, " dmem_req cycles"}, dmem_cycles, me.dmem_cycles);
          check({me.name, " dmem_we"}, dmem_we_seen, me.dmem_we);
          check({me.name, " retired"}, bus.retired, me.retired_before);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.opcode = '0; bus.rd = '0; bus.br_taken = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;

    // Reset, IDLE, first FETCH
    repeat (2) step();
    check_reset_state("reset");
    rst = 1'b1;
    step();
    check("first fetch imem_req", bus.imem_req, 1);
    check("first fetch cycle_cnt", bus.cycle_cnt, 1);

    //      name      opcode        rd    br iw mem dw  psel rfwe lat dm dwe ret
    do_insn("ADD",    7'b0110011, 5'd5, 0, 0, 0,  0,  0,   1,   4,  0, 0,  0);
    do_insn("LOAD",   7'b0000011, 5'd7, 0, 0, 1,  3,  0,   1,   8,  4, 0,  1);
    do_insn("BRANCH", 7'b1100011, 5'd9, 1, 0, 0,  0,  1,   0,   3,  0, 0,  2);
    do_insn("STORE",  7'b0100011, 5'd3, 0, 2, 1,  0,  0,   0,   6,  1, 1,  3);
    do_insn("JAL",    7'b1101111, 5'd1, 0, 0, 0,  0,  1,   1,   4,  0, 0,  4);
    do_insn("ADDI",   7'b0010011, 5'd0, 0, 0, 0,  0,  0,   0,   4,  0, 0,  5);

    // Illegal opcode: halts after DECODE, not retired
    bus.opcode = 7'b1111111;
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    step();
    check("illegal halted", bus.halted, 1);
    check("illegal illegal", bus.illegal, 1);
    check("illegal bus_err", bus.bus_err, 0);
    check("illegal retired", bus.retired, 6);
    check("illegal cycle_cnt", bus.cycle_cnt, 32);
    bus.imem_ready = 1'b1;
    #1;
    check("halt ignores imem_ready", bus.insn_we, 0);
    repeat (3) step();
    bus.imem_ready = 1'b0;
    check("halt cycle_cnt frozen", bus.cycle_cnt, 32);
    check("halt imem_req", bus.imem_req, 0);

    // Reset clears sticky flags; then reset in the middle of MEMORY
    rst = 1'b0;
    repeat (2) step();
    check_reset_state("reset after halt");
    rst = 1'b1;
    step();
    bus.opcode = 7'b0000011; bus.rd = 5'd4;
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    repeat (2) step();
    check("mid-mem dmem_req", bus.dmem_req, 1);
    check("mid-mem dmem_we", bus.dmem_we, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check_reset_state("reset mid-mem");
    rst = 1'b1;
    step();
    check("refetch imem_req", bus.imem_req, 1);
    check("refetch cycle_cnt", bus.cycle_cnt, 1);

    // Fetch wait timeout: MAX_WAIT = 4
    repeat (3) step();
    check("wait 4 imem_req", bus.imem_req, 1);
    check("wait 4 bus_err", bus.bus_err, 0);
    step();
    check("timeout bus_err", bus.bus_err, 1);
    check("timeout halted", bus.halted, 1);
    check("timeout illegal", bus.illegal, 0);
    check("timeout imem_req", bus.imem_req, 0);
    check("timeout cycle_cnt", bus.cycle_cnt, 5);
    repeat (2) step();
    check("timeout imem_req later", bus.imem_req, 0);
    check("timeout retired", bus.retired, 0);

    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
